// File: rtl/xort_sched_pkg.sv
// Shared types, default timing windows and helpers for the XORT pulse scheduler.
package xort_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_A    = 2'd1,
    ST_B    = 2'd2
  } cell_state_e;

  localparam int CNT_W_DEF       = 5;
  localparam int CT_SETUP_DEF    = 3;
  localparam int CT_CROSS_DEF    = 13;
  localparam int CT_DATA_CLK_DEF = 15;
  localparam int CT_SELF_DEF     = 4;
  localparam int CT_CLK_HOLD_DEF = 4;
  localparam int CLKQ_DLY_DEF    = 6;

  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_CLK = 2;
  localparam int N_CH   = 3;

  // The grant tick is the first tick of a window, so a window of w ticks
  // leaves w-1 ticks still to run once the load edge has passed.
  function automatic int unsigned lock_max(input int unsigned cur, input int unsigned win);
    int unsigned dec;
    int unsigned fresh;
    dec   = (cur == 0) ? 0 : cur - 1;
    fresh = (win == 0) ? 0 : win - 1;
    return (fresh > dec) ? fresh : dec;
  endfunction

  // ceil(dly / (1 + hold)) + 1 entries of pending q toggles
  function automatic int unsigned fifo_depth(input int unsigned dly, input int unsigned hold);
    return (dly + hold) / (1 + hold) + 1;
  endfunction

endpackage

// File: rtl/xort_lockout_ctr.sv
// Saturating lockout down-counter; a load never shortens a window already running.
module xort_lockout_ctr
  import xort_sched_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    if (load) begin
      cnt_next = CNT_W'(lock_max(32'(cnt_reg), 32'(load_val)));
    end else begin
      cnt_next = (cnt_reg == '0) ? '0 : cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/xort_pulse_scheduler.sv
// Tick-based pulse issue controller and q predictor for the clocked-XOR RSFQ cell.
// Define XORT_SCHED_RR_EN for round-robin arbitration between a and b.
module xort_pulse_scheduler
  import xort_sched_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int CT_SETUP    = CT_SETUP_DEF,
  parameter int CT_CROSS    = CT_CROSS_DEF,
  parameter int CT_DATA_CLK = CT_DATA_CLK_DEF,
  parameter int CT_SELF     = CT_SELF_DEF,
  parameter int CT_CLK_HOLD = CT_CLK_HOLD_DEF,
  parameter int CLKQ_DLY    = CLKQ_DLY_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       req_clk,
  output logic       ack_a,
  output logic       ack_b,
  output logic       ack_clk,
  output logic       a_out,
  output logic       b_out,
  output logic       clk_out,
  output logic       q_pred,
  output logic       q_valid,
  output logic [1:0] cell_state
);

  localparam int FIFO_D = fifo_depth(CLKQ_DLY, CT_CLK_HOLD);
  localparam int PTR_W  = $clog2(FIFO_D);
  localparam int FILL_W = PTR_W + 1;

  logic [N_CH-1:0]  req_vec;
  logic [N_CH-1:0]  elig_vec;
  logic [N_CH-1:0]  load_vec;
  logic [CNT_W-1:0] load_val [N_CH];
  logic [CNT_W-1:0] lock_cnt [N_CH];

  assign req_vec = {req_clk, req_b, req_a};

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_lock
      xort_lockout_ctr #(.CNT_W(CNT_W)) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (load_vec[gi]),
        .load_val (load_val[gi]),
        .cnt      (lock_cnt[gi])
      );
      assign elig_vec[gi] = req_vec[gi] & (lock_cnt[gi] == '0);
    end
  endgenerate

  logic a_wins;

`ifdef XORT_SCHED_RR_EN
  logic rr_b_first_reg;
  logic rr_b_first_next;

  // The pointer only moves when a and b actually contend for the same tick.
  always_comb begin
    rr_b_first_next = rr_b_first_reg;
    if (!elig_vec[CH_CLK] && elig_vec[CH_A] && elig_vec[CH_B]) begin
      rr_b_first_next = ack_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_b_first_reg <= 1'b0;
    end else begin
      rr_b_first_reg <= rr_b_first_next;
    end
  end

  assign a_wins = elig_vec[CH_A] & ~(elig_vec[CH_B] & rr_b_first_reg);
`else
  assign a_wins = elig_vec[CH_A];
`endif

  assign ack_clk = elig_vec[CH_CLK];
  assign ack_a   = ~ack_clk & a_wins;
  assign ack_b   = ~ack_clk & ~ack_a & elig_vec[CH_B];

  cell_state_e state_reg;
  cell_state_e state_next;
  logic        q_sched;

  always_comb begin
    state_next = state_reg;
    load_vec   = '0;
    for (int i = 0; i < N_CH; i++) begin
      load_val[i] = '0;
    end
    q_sched = 1'b0;

    if (ack_clk) begin
      case (state_reg)
        ST_A: begin
          state_next       = ST_IDLE;
          load_vec[CH_B]   = 1'b1;
          load_val[CH_B]   = CNT_W'(CT_CLK_HOLD);
          q_sched          = 1'b1;
        end
        ST_B: begin
          state_next       = ST_IDLE;
          load_vec[CH_A]   = 1'b1;
          load_val[CH_A]   = CNT_W'(CT_CLK_HOLD);
          q_sched          = 1'b1;
        end
        default: ;
      endcase
    end else if (ack_a) begin
      case (state_reg)
        ST_IDLE: begin
          state_next       = ST_A;
          load_vec[CH_CLK] = 1'b1;
          load_val[CH_CLK] = CNT_W'(CT_SETUP);
        end
        ST_A: begin
          load_vec[CH_B]   = 1'b1;
          load_val[CH_B]   = CNT_W'(CT_CROSS);
          load_vec[CH_CLK] = 1'b1;
          load_val[CH_CLK] = CNT_W'(CT_DATA_CLK);
        end
        ST_B: begin
          state_next       = ST_IDLE;
          load_vec[CH_A]   = 1'b1;
          load_val[CH_A]   = CNT_W'(CT_SELF);
        end
        default: state_next = ST_IDLE;
      endcase
    end else if (ack_b) begin
      case (state_reg)
        ST_IDLE: begin
          state_next       = ST_B;
          load_vec[CH_CLK] = 1'b1;
          load_val[CH_CLK] = CNT_W'(CT_SETUP);
        end
        ST_B: begin
          load_vec[CH_A]   = 1'b1;
          load_val[CH_A]   = CNT_W'(CT_CROSS);
          load_vec[CH_CLK] = 1'b1;
          load_val[CH_CLK] = CNT_W'(CT_DATA_CLK);
        end
        ST_A: begin
          state_next       = ST_IDLE;
          load_vec[CH_B]   = 1'b1;
          load_val[CH_B]   = CNT_W'(CT_SELF);
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  logic a_out_reg, b_out_reg, clk_out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      a_out_reg   <= 1'b0;
      b_out_reg   <= 1'b0;
      clk_out_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      a_out_reg   <= a_out_reg ^ ack_a;
      b_out_reg   <= b_out_reg ^ ack_b;
      clk_out_reg <= clk_out_reg ^ ack_clk;
    end
  end

  // Pending q toggles are stored as the free-running tick on which they fire.
  logic [CNT_W-1:0]  tick_reg;
  logic [CNT_W-1:0]  fifo_mem [FIFO_D];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [FILL_W-1:0] fill_reg;
  logic              q_due;
  logic              q_pred_reg, q_valid_reg;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign q_due = (fill_reg != '0) && (fifo_mem[rd_ptr_reg] == tick_reg);

  always_ff @(posedge clk) begin
    if (q_sched) begin
      fifo_mem[wr_ptr_reg] <= tick_reg + CNT_W'(CLKQ_DLY - 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg    <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      fill_reg    <= '0;
      q_pred_reg  <= 1'b0;
      q_valid_reg <= 1'b0;
    end else begin
      tick_reg    <= tick_reg + CNT_W'(1);
      q_valid_reg <= q_due;
      if (q_due) begin
        q_pred_reg <= ~q_pred_reg;
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      if (q_sched) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      case ({q_sched, q_due})
        2'b10:   fill_reg <= fill_reg + FILL_W'(1);
        2'b01:   fill_reg <= fill_reg - FILL_W'(1);
        default: ;
      endcase
    end
  end

  assign a_out      = a_out_reg;
  assign b_out      = b_out_reg;
  assign clk_out    = clk_out_reg;
  assign q_pred     = q_pred_reg;
  assign q_valid    = q_valid_reg;
  assign cell_state = state_reg;

endmodule

// File: tb/tb_xort_pulse_scheduler.sv
// Directed scoreboard bench for xort_pulse_scheduler (also run with XORT_SCHED_RR_EN).
module tb_xort_pulse_scheduler;

  localparam int CH_A   = 0;
  localparam int CH_B   = 1;
  localparam int CH_CLK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0, req_clk = 1'b0;
  logic       ack_a, ack_b, ack_clk;
  logic       a_out, b_out, clk_out, q_pred, q_valid;
  logic [1:0] cell_state;

  typedef struct { int ch; int t; } grant_exp_t;
  typedef struct { int t; logic q; } q_exp_t;

  grant_exp_t grant_q[$];
  q_exp_t     q_q[$];
  q_exp_t     qe;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  logic [2:0] out_model = 3'b000;  // bit0 a_out, bit1 b_out, bit2 clk_out

  xort_pulse_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_clk    (req_clk),
    .ack_a      (ack_a),
    .ack_b      (ack_b),
    .ack_clk    (ack_clk),
    .a_out      (a_out),
    .b_out      (b_out),
    .clk_out    (clk_out),
    .q_pred     (q_pred),
    .q_valid    (q_valid),
    .cell_state (cell_state)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic string ch_str(input int ch);
    case (ch)
      0:       return "a";
      1:       return "b";
      2:       return "clk";
      default: return "none";
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d (t=%0d)", tag, obs, exp, cyc - t0);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_grant(input int ch, input int t);
    grant_exp_t e;
    e.ch = ch;
    e.t  = t;
    grant_q.push_back(e);
  endtask

  task automatic expect_q(input int t, input logic q);
    q_exp_t e;
    e.t = t;
    e.q = q;
    q_q.push_back(e);
  endtask

  task automatic sb_grant(input int ch);
    grant_exp_t e;
    e.ch = -1;
    e.t  = -1;
    if (grant_q.size() > 0) e = grant_q.pop_front();
    $display("[TB] t=%0d grant %s (expected %s at t=%0d)", cyc - t0, ch_str(ch), ch_str(e.ch), e.t - t0);
    chk("grant_channel", ch, e.ch);
    chk("grant_tick", cyc - t0, e.t - t0);
    if (e.ch >= 0) out_model[e.ch] = ~out_model[e.ch];
  endtask

  // Observe transfers at the falling edge, drop granted requests after the next rising edge.
  task automatic run(input int budget);
    int n;
    logic [2:0] done;
    n = 0;
    while ((req_a || req_b || req_clk) && n < budget) begin
      @(negedge clk);
      done = {req_clk && ack_clk, req_b && ack_b, req_a && ack_a};
      for (int i = 0; i < 3; i++) begin
        if (done[i]) sb_grant(i);
      end
      @(posedge clk);
      #1;
      if (done[CH_A])   req_a   = 1'b0;
      if (done[CH_B])   req_b   = 1'b0;
      if (done[CH_CLK]) req_clk = 1'b0;
      n++;
    end
    chk("run_all_granted", {29'd0, req_clk, req_b, req_a}, 0);
    req_a   = 1'b0;
    req_b   = 1'b0;
    req_clk = 1'b0;
  endtask

  task automatic chk_outs(input int st);
    chk("a_out", a_out, out_model[0]);
    chk("b_out", b_out, out_model[1]);
    chk("clk_out", clk_out, out_model[2]);
    chk("cell_state", cell_state, st);
  endtask

  always @(negedge clk) begin
    if (q_valid !== 1'b0) begin
      if (q_q.size() > 0) begin
        qe = q_q.pop_front();
        $display("[TB] t=%0d q_valid q_pred=%0b (expected t=%0d q=%0b)", cyc - t0, q_pred, qe.t - t0, qe.q);
        chk("q_tick", cyc - t0, qe.t - t0);
        chk("q_level", q_pred, qe.q);
      end else begin
        chk("q_valid_spurious", q_valid, 0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, u, v, w, x;

    rst = 1'b1;
    adv(3);
    chk_outs(0);
    chk("reset_q_pred", q_pred, 0);
    chk("reset_q_valid", q_valid, 0);
    rst = 1'b0;
    t0 = cyc;

    // a at tick 10, clk held from 11 waits for the setup window
    adv(10);
    expect_grant(CH_A, t0 + 10);
    req_a = 1'b1;
    run(8);
    chk_outs(1);
    expect_grant(CH_CLK, t0 + 13);
    expect_q(t0 + 19, 1'b1);
    req_clk = 1'b1;
    run(8);
    chk_outs(0);
    expect_grant(CH_B, t0 + 17);
    req_b = 1'b1;
    run(8);
    chk_outs(2);
    expect_grant(CH_CLK, t0 + 20);
    expect_q(t0 + 26, 1'b0);
    req_clk = 1'b1;
    run(8);
    chk_outs(0);
    chk("q_pred_first_toggle", q_pred, 1);
    adv(6);
    chk("q_pred_second_toggle", q_pred, 0);

    // a then b on consecutive ticks: b self-recovery, clk lockout untouched
    t = cyc;
    expect_grant(CH_A, t);
    req_a = 1'b1;
    run(8);
    chk_outs(1);
    expect_grant(CH_B, t + 1);
    req_b = 1'b1;
    run(8);
    chk_outs(0);
    expect_grant(CH_CLK, t + 3);
    expect_grant(CH_B, t + 5);
    req_clk = 1'b1;
    req_b   = 1'b1;
    run(12);
    chk_outs(2);
    expect_grant(CH_A, t + 6);
    req_a = 1'b1;
    run(8);
    chk_outs(0);
    adv(4);

    // simultaneous a/b twice
    u = cyc;
    expect_grant(CH_A, u);
    expect_grant(CH_B, u + 1);
    req_a = 1'b1;
    req_b = 1'b1;
    run(8);
    chk_outs(0);
    adv(3);
    u = cyc;
`ifdef XORT_SCHED_RR_EN
    expect_grant(CH_B, u);
    expect_grant(CH_A, u + 1);
`else
    expect_grant(CH_A, u);
    expect_grant(CH_B, u + 1);
`endif
    req_a = 1'b1;
    req_b = 1'b1;
    run(8);
    chk_outs(0);
    adv(4);

    // two a grants in state 1: cross and data-clk windows
    v = cyc;
    expect_grant(CH_A, v);
    req_a = 1'b1;
    run(8);
    chk_outs(1);
    expect_grant(CH_A, v + 1);
    req_a = 1'b1;
    run(8);
    chk_outs(1);
    expect_grant(CH_B, v + 14);
    expect_grant(CH_CLK, v + 16);
    req_b   = 1'b1;
    req_clk = 1'b1;
    run(20);
    chk_outs(0);
    chk("q_pred_after_cross", q_pred, 0);

    // reset two ticks after a q-producing clk grant discards the pending toggle
    w = cyc;
    expect_grant(CH_A, w);
    req_a = 1'b1;
    run(8);
    chk_outs(1);
    adv(2);
    expect_grant(CH_CLK, w + 3);
    req_clk = 1'b1;
    run(8);
    chk_outs(0);
    expect_grant(CH_A, w + 4);
    req_a = 1'b1;
    run(8);
    chk_outs(1);
    rst = 1'b1;
    adv(2);
    out_model = 3'b000;
    chk_outs(0);
    chk("rst_q_pred", q_pred, 0);
    chk("rst_q_valid", q_valid, 0);
    rst = 1'b0;
    adv(5);
    chk("post_rst_q_pred", q_pred, 0);
    x = cyc;
    expect_grant(CH_CLK, x);
    req_clk = 1'b1;
    run(4);
    chk_outs(0);

    adv(10);
    chk("grant_queue_drained", grant_q.size(), 0);
    chk("q_queue_drained", q_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xort_pulse_scheduler.md
Name: xort_pulse_scheduler

Overview:
- Tick-based issue controller for the clocked-XOR (XORT) RSFQ cell.
- Accepts pulse requests for the cell's a, b and clk inputs from three requesters.
- Issues each pulse as a level toggle, since the cell reacts to both edges, and grants one pulse per tick.
- Holds back any pulse that would land inside a critical-timing window of the cell, tracks a shadow copy of the cell state, and predicts the q output.

Parameters:
- CNT_W, 5, width of lockout and delay counters.
- CT_SETUP, 3, ticks: state0 a->clk and state0 b->clk lockout.
- CT_CROSS, 13, ticks: state1 a->b and state2 b->a lockout.
- CT_DATA_CLK, 15, ticks: state1 a->clk and state2 b->clk lockout.
- CT_SELF, 4, ticks: state1 b->b and state2 a->a lockout (cancel recovery).
- CT_CLK_HOLD, 4, ticks: state1 clk->b and state2 clk->a lockout.
- CLKQ_DLY, 6, ticks from clk issue to q_pred update.

Ports:
- clk, in, 1: scheduler tick clock; 1 tick = 1 ps of cell time.
- rst, in, 1: synchronous, active-high reset.
- req_a, req_b, req_clk, in, 1 each: pulse request; held high until acked.
- ack_a, ack_b, ack_clk, out, 1 each: combinational grant; a transfer occurs when req and ack are both high at the rising edge.
- a_out, b_out, clk_out, out, 1 each: toggle-encoded pulse lines to the cell.
- q_pred, out, 1: predicted cell q level.
- q_valid, out, 1: one-tick strobe when q_pred toggles.
- cell_state, out, 2: shadow state. 0 = idle, 1 = a stored, 2 = b stored.

Behaviour:
- Reset value of every output and register is 0 when rst is high at an edge: a_out, b_out, clk_out, counters, cell_state, q_pred, q_valid, and any pending q update.
  - rst overrides all other activity.
  - Reset mid-operation discards pending q updates and lockouts.
  - Reset does not reach the cell; the integrator resets both together.
- Lockout counters: lock_a, lock_b, lock_clk.
  - Each decrements by 1 per tick, saturating at 0.
  - An input is eligible when its req is high and its counter is 0.
  - Loads take max(current-1, new value), so a shorter window never shortens an active one.
- Grant rules:
  - At most one grant per tick.
  - clk has highest priority.
  - Between a and b the order is fixed, a before b, unless the optional feature is enabled.
  - On grant, the matching *_out toggles at that edge.
- State and lockout updates on grant (shadow of the cell):
  - a in state0: state becomes 1; lock_clk loaded with CT_SETUP.
  - a in state1: state stays 1; lock_b loaded with CT_CROSS; lock_clk loaded with CT_DATA_CLK.
  - a in state2: state becomes 0; lock_a loaded with CT_SELF.
  - b: symmetric to a, with the roles of a and b swapped and state2 in place of state1.
  - clk in state0: no change.
  - clk in state1: state becomes 0; lock_b loaded with CT_CLK_HOLD; a q toggle is scheduled.
  - clk in state2: state becomes 0; lock_a loaded with CT_CLK_HOLD; a q toggle is scheduled.
- q prediction:
  - A scheduled toggle flips q_pred exactly CLKQ_DLY ticks after the clk grant edge, with q_valid high for that tick.
  - A delay FIFO of depth ceil(CLKQ_DLY / (1+CT_CLK_HOLD)) + 1 holds pending toggles.
  - The FIFO can never overflow, because clk grants in state1/2 are at least 1 tick apart and state must refill first.
- Latency: with an eligible request and no higher-priority competitor, ack is high in the same tick as req, and the *_out toggle is visible the next tick.
- Starvation: a request blocked by its lockout waits; there is no timeout.
- Simultaneous requests: losers keep req high and retry every tick.

Optional Feature:
- XORT_SCHED_RR_EN defined: round-robin between a and b. The last granted of a/b gets lowest priority next time both are eligible. clk stays highest.
- Undefined: fixed priority clk > a > b.

Decomposition:
- Package xort_sched_pkg:
  - cell-state enum (ST_IDLE, ST_A, ST_B);
  - CNT_W default;
  - default CT_* and CLKQ_DLY constants;
  - a max-load helper function.
- Sub-module xort_lockout_ctr: saturating down-counter with max-load input. Instantiated three times.

Test Plan:
- Reset, then req_a at tick 10 → ack_a at tick 10, a_out=1 at tick 11, cell_state=1; req_clk held from tick 11 → ack_clk at tick 13, not earlier.
- a granted at t=10, clk at t=13 → q_pred toggles to 1 at t=19 with a 1-tick q_valid; cell_state=0; req_b at t=14 acks at t=17.
- a then b at consecutive ticks (state 1 → 0) → a second req_b acks no earlier than 4 ticks after the first b grant; lock_clk is not extended.
- req_a and req_b asserted together in state0 → ack_a first. Same again: ack_a first without XORT_SCHED_RR_EN, ack_b first with it.
- Two a grants in state1 → lock_b = 13, lock_clk = 15 from the second grant; req_clk waits the full 15 ticks.
- Assert rst 2 ticks after a clk grant → q_pred stays 0, q_valid never strobes, all outputs 0, next req_clk acks immediately.
